// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Brief    : Operand/result valid-ready bundle for the multi-cycle ALU.
// Revision : 1.0
// ============================================================================
interface alu_mc_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   ALU_Sel;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] ALU_Result;
    logic [3:0]   ALU_Flags;

    modport master (
        output in_valid, A, B, ALU_Sel, out_ready,
        input  in_ready, out_valid, ALU_Result, ALU_Flags
    );

    modport slave (
        input  in_valid, A, B, ALU_Sel, out_ready,
        output in_ready, out_valid, ALU_Result, ALU_Flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : 8-op ALU with registered result/flags and a shift-add multiplier.
// Revision : 1.0
// ============================================================================
module alu_mc #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0]    c_op_add = 3'b000;
    localparam logic [2:0]    c_op_sub = 3'b001;
    localparam logic [2:0]    c_op_and = 3'b010;
    localparam logic [2:0]    c_op_orr = 3'b011;
    localparam logic [2:0]    c_op_eor = 3'b100;
    localparam logic [2:0]    c_op_lsl = 3'b101;
    localparam logic [2:0]    c_op_lsr = 3'b110;
    localparam logic [2:0]    c_op_mul = 3'b111;
    localparam logic [SW-1:0] c_last   = SW'(N - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_in_ready;
    logic           w_out_valid;

    logic [N-1:0]   r_result;
    logic [3:0]     r_flags;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [SW-1:0]  r_count;

    logic [SW-1:0]  w_sh;
    logic [N:0]     w_sum;
    logic [N:0]     w_dif;
    logic [N:0]     w_lsl;
    logic [N:0]     w_lsr;
    logic [2*N-1:0] w_acc_nxt;
    logic [N-1:0]   w_res;
    logic           w_c;
    logic           w_v;

    // Shifts run one bit wider so the last bit shifted out lands in the extra
    // position; a zero shift leaves that position 0, giving C=0 for free.
    assign w_sh      = bus.B[SW-1:0];
    assign w_sum     = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_dif     = {1'b0, bus.A} + {1'b0, ~bus.B} + {{N{1'b0}}, 1'b1};
    assign w_lsl     = {1'b0, bus.A} << w_sh;
    assign w_lsr     = {bus.A, 1'b0} >> w_sh;
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.ALU_Sel)
            c_op_add: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (bus.A[N-1] == bus.B[N-1]) && (w_sum[N-1] != bus.A[N-1]);
            end
            c_op_sub: begin
                w_res = w_dif[N-1:0];
                w_c   = w_dif[N];
                w_v   = (bus.A[N-1] != bus.B[N-1]) && (w_dif[N-1] != bus.A[N-1]);
            end
            c_op_and: w_res = bus.A & bus.B;
            c_op_orr: w_res = bus.A | bus.B;
            c_op_eor: w_res = bus.A ^ bus.B;
            c_op_lsl: begin
                w_res = w_lsl[N-1:0];
                w_c   = w_lsl[N];
            end
            c_op_lsr: begin
                w_res = w_lsr[N:1];
                w_c   = w_lsr[0];
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (bus.ALU_Sel == c_op_mul) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (r_count == c_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            if (bus.ALU_Sel == c_op_mul) begin
                r_mcand  <= {{N{1'b0}}, bus.A};
                r_mplier <= bus.B;
                r_acc    <= '0;
                r_count  <= '0;
            end else begin
                r_result <= w_res;
                r_flags  <= {w_res[N-1], (w_res == '0), w_c, w_v};
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            // Final step writes the product straight out, saving a cycle.
            if (r_count == c_last) begin
                r_result <= w_acc_nxt[N-1:0];
                r_flags  <= {w_acc_nxt[N-1], (w_acc_nxt[N-1:0] == '0),
                             (|w_acc_nxt[2*N-1:N]), 1'b0};
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.ALU_Result = r_result;
    assign bus.ALU_Flags  = r_flags;

endmodule
`default_nettype wire
